seq_sub_64: RTL

Multi-cycle 64-bit subtractor, the inverse-operation companion of the 64-bit ripple-carry adder in the arithmetic datapath. It computes D = A − B − bin in 8-bit slices, one slice per clock, using a start/busy/done handshake. This trades latency for a short critical path. Results are registered and held stable until the next operation completes. It produces borrow-out, zero and signed-overflow flags for the downstream compare and branch logic.

---
 rtl/arith_pkg.sv | 15 +
 rtl/sub_slice_8.sv | 27 ++
 rtl/seq_sub_64.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: default operand geometry and the
// sequential-unit FSM state encoding.
package arith_pkg;

   localparam int unsigned DEF_WIDTH  = 64;
   localparam int unsigned DEF_SLICE  = 8;
   localparam int unsigned DEF_NSLICE = DEF_WIDTH / DEF_SLICE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sub_slice_8.sv
// Combinational ripple-borrow subtractor for one slice: {bo, d} = a - b - bi,
// built as a chain of full-subtractor cells.
module sub_slice_8
   import arith_pkg::*;
#(
   parameter int unsigned W = DEF_SLICE
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bi,
   output logic [W-1:0] d,
   output logic         bo
);

   logic [W:0] br;

   assign br[0] = bi;

   // Full-subtractor cell: borrow when a < b + borrow-in at this bit
   for (genvar i = 0; i < W; i++) begin : g_cell
      assign d[i]    = a[i] ^ b[i] ^ br[i];
      assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
   end

   assign bo = br[W];

endmodule

// File: rtl/seq_sub_64.sv
// Multi-cycle subtractor: D = A - B - bin processed one slice per clock,
// with a start/busy/done handshake and registered borrow/zero/overflow flags.
module seq_sub_64
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] work_n;
   logic [IDXW-1:0]  idx_q;
   logic             br_q;
   logic             load;
   logic             step;
   logic             last;
   logic             finish;
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE-1:0] r_sl;
   logic             bo_sl;

   assign last = (idx_q == IDXW'(NSLICE - 1));

   // Select the operand slices addressed by the running index
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int unsigned k = 0; k < NSLICE; k++) begin
         if (idx_q == IDXW'(k)) begin
            a_sl = a_q[k*SLICE +: SLICE];
            b_sl = b_q[k*SLICE +: SLICE];
         end
      end
   end

   sub_slice_8 #(.W(SLICE)) u_slice (
      .a  (a_sl),
      .b  (b_sl),
      .bi (br_q),
      .d  (r_sl),
      .bo (bo_sl)
   );

   // Work register with the current slice result merged in
   always_comb begin
      work_n = work_q;
      for (int unsigned k = 0; k < NSLICE; k++) begin
         if (idx_q == IDXW'(k)) begin
            work_n[k*SLICE +: SLICE] = r_sl;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               finish  = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Operand latch, slice iteration and result/flag capture on the final slice
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         work_q <= '0;
         idx_q  <= '0;
         br_q   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         D      <= '0;
         bout   <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         busy <= (state_n == RUN);
         done <= (state_n == DONE);
         if (load) begin
            a_q   <= A;
            b_q   <= B;
            br_q  <= bin;
            idx_q <= '0;
         end else if (step) begin
            work_q <= work_n;
            br_q   <= bo_sl;
            idx_q  <= idx_q + IDXW'(1);
         end
         if (finish) begin
            D    <= work_n;
            bout <= bo_sl;
            zero <= (work_n == '0);
            ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_n[WIDTH-1] != a_q[WIDTH-1]);
         end
      end
   end

endmodule
